// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter/receiver pair.
package uart_pkg;

  localparam int                      BIT_PERIOD_W   = 16;
  localparam logic [BIT_PERIOD_W-1:0] MIN_BIT_PERIOD = 16'd4;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Mode code 3 is treated the same as "no parity".
  function automatic parity_e decode_parity(input logic [1:0] mode);
    case (mode)
      2'd1:    return PAR_EVEN;
      2'd2:    return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

  function automatic logic parity_bit(input parity_e mode, input logic [7:0] data);
    return (mode == PAR_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter: tick is high N cycles after a load of N.
import uart_pkg::*;

module uart_bit_timer (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [BIT_PERIOD_W-1:0] load_val,
  output logic                    tick
);

  logic [BIT_PERIOD_W-1:0] cnt;

  // Count down to zero and hold there until the next load
  always_ff @(posedge clk) begin
    if (rst)              cnt <= '0;
    else if (load)        cnt <= load_val - 1'b1;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex 8-bit UART with runtime-programmable bit period.
//
// state     | meaning
// ----------+------------------------------------------------
// ST_IDLE   | line idle; TX waits for tx_en, RX for a falling edge
// ST_START  | TX drives start bit; RX waits half a bit to re-check it
// ST_DATA   | 8 data bits, LSB first, one per bit period
// ST_PARITY | parity bit (skipped when parity is off)
// ST_STOP   | TX drives stop bit; RX samples it and delivers the byte
import uart_pkg::*;

module uart_transceiver #(
  parameter int BAUD_RATE = 115200,
  parameter int CLK_FREQ  = 25000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_bit_period_i,
  input  logic [BIT_PERIOD_W-1:0] bit_period_i,
  input  logic [1:0]              parity_type_i,
  input  logic                    uart_tx_en,
  input  logic [7:0]              uart_tx_data,
  output logic                    uart_txd,
  output logic                    uart_tx_busy,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_valid_o,
  output logic [7:0]              uart_rx_data,
  output logic                    uart_rx_parity_error_o
);

  localparam logic [BIT_PERIOD_W-1:0] RESET_PERIOD = BIT_PERIOD_W'(CLK_FREQ / BAUD_RATE);

  logic [BIT_PERIOD_W-1:0] period_q;

  // Bit period register, clamped to the shortest usable period
  always_ff @(posedge clk) begin
    if (rst)                  period_q <= RESET_PERIOD;
    else if (wr_bit_period_i) period_q <= (bit_period_i < MIN_BIT_PERIOD) ? MIN_BIT_PERIOD : bit_period_i;
  end

  // ---------------- transmitter ----------------
  uart_state_e             tx_state;
  logic [7:0]              tx_shift;
  logic [2:0]              tx_bit_idx;
  parity_e                 tx_par_mode;
  logic                    tx_par_bit;
  logic [BIT_PERIOD_W-1:0] tx_period;
  logic                    tx_tick;
  logic                    tx_load;
  logic [BIT_PERIOD_W-1:0] tx_load_val;

  // The frame's period is copied at start so mid-frame writes only affect the next frame.
  assign tx_load     = ((tx_state == ST_IDLE) && uart_tx_en) || ((tx_state != ST_IDLE) && tx_tick);
  assign tx_load_val = (tx_state == ST_IDLE) ? period_q : tx_period;

  uart_bit_timer u_tx_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tx_load),
    .load_val (tx_load_val),
    .tick     (tx_tick)
  );

  // TX sequencing: advance one bit per timer tick
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state    <= ST_IDLE;
      tx_shift    <= '0;
      tx_bit_idx  <= '0;
      tx_par_mode <= PAR_NONE;
      tx_par_bit  <= 1'b0;
      tx_period   <= RESET_PERIOD;
    end else begin
      case (tx_state)
        ST_IDLE: if (uart_tx_en) begin
          tx_state    <= ST_START;
          tx_shift    <= uart_tx_data;
          tx_bit_idx  <= '0;
          tx_par_mode <= decode_parity(parity_type_i);
          tx_par_bit  <= parity_bit(decode_parity(parity_type_i), uart_tx_data);
          tx_period   <= period_q;
        end
        ST_START: if (tx_tick) tx_state <= ST_DATA;
        ST_DATA: if (tx_tick) begin
          tx_shift   <= {1'b1, tx_shift[7:1]};
          tx_bit_idx <= tx_bit_idx + 3'd1;
          if (tx_bit_idx == 3'd7) tx_state <= (tx_par_mode == PAR_NONE) ? ST_STOP : ST_PARITY;
        end
        ST_PARITY: if (tx_tick) tx_state <= ST_STOP;
        ST_STOP:   if (tx_tick) tx_state <= ST_IDLE;
        default:   tx_state <= ST_IDLE;
      endcase
    end
  end

  // Serial line level follows the current TX state
  always_comb begin
    uart_txd = 1'b1;
    case (tx_state)
      ST_START:  uart_txd = 1'b0;
      ST_DATA:   uart_txd = tx_shift[0];
      ST_PARITY: uart_txd = tx_par_bit;
      default:   uart_txd = 1'b1;
    endcase
  end

  assign uart_tx_busy = (tx_state != ST_IDLE);

  // ---------------- receiver ----------------
  logic                    rxd_meta;
  logic                    rxd_sync;
  logic                    rxd_prev;
  logic                    rx_fall;
  logic                    rx_start;
  uart_state_e             rx_state;
  logic [7:0]              rx_shift;
  logic [2:0]              rx_bit_idx;
  parity_e                 rx_par_mode;
  logic                    rx_par_bit;
  logic [BIT_PERIOD_W-1:0] rx_period;
  logic                    rx_tick;
  logic                    rx_load;
  logic [BIT_PERIOD_W-1:0] rx_load_val;

  // Two-flop synchronizer plus one delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  // A falling edge implies the line was high first, which also re-arms after a framing error.
  assign rx_fall     = rxd_prev & ~rxd_sync;
  assign rx_start    = (rx_state == ST_IDLE) && uart_rx_en && rx_fall;
  assign rx_load     = rx_start || ((rx_state != ST_IDLE) && rx_tick);
  assign rx_load_val = (rx_state == ST_IDLE) ? (period_q >> 1) : rx_period;

  uart_bit_timer u_rx_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (rx_load),
    .load_val (rx_load_val),
    .tick     (rx_tick)
  );

  // RX sequencing: sample mid-bit on each tick, deliver byte after a good stop bit
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state               <= ST_IDLE;
      rx_shift               <= '0;
      rx_bit_idx             <= '0;
      rx_par_mode            <= PAR_NONE;
      rx_par_bit             <= 1'b0;
      rx_period              <= RESET_PERIOD;
      uart_rx_valid_o        <= 1'b0;
      uart_rx_data           <= '0;
      uart_rx_parity_error_o <= 1'b0;
    end else begin
      uart_rx_valid_o        <= 1'b0;
      uart_rx_parity_error_o <= 1'b0;
      case (rx_state)
        ST_IDLE: if (rx_start) begin
          rx_state    <= ST_START;
          rx_period   <= period_q;
          rx_par_mode <= decode_parity(parity_type_i);
          rx_bit_idx  <= '0;
        end
        ST_START: if (rx_tick) rx_state <= rxd_sync ? ST_IDLE : ST_DATA;
        ST_DATA: if (rx_tick) begin
          rx_shift   <= {rxd_sync, rx_shift[7:1]};
          rx_bit_idx <= rx_bit_idx + 3'd1;
          if (rx_bit_idx == 3'd7) rx_state <= (rx_par_mode == PAR_NONE) ? ST_STOP : ST_PARITY;
        end
        ST_PARITY: if (rx_tick) begin
          rx_par_bit <= rxd_sync;
          rx_state   <= ST_STOP;
        end
        ST_STOP: if (rx_tick) begin
          rx_state <= ST_IDLE;
          if (rxd_sync) begin
            uart_rx_data           <= rx_shift;
            uart_rx_valid_o        <= 1'b1;
            uart_rx_parity_error_o <= (rx_par_mode != PAR_NONE) &&
                                      (rx_par_bit != parity_bit(rx_par_mode, rx_shift));
          end
        end
        default: rx_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transceiver.sv
// Self-checking bench for uart_transceiver.
`timescale 1ns/1ps
module tb_uart_transceiver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_bit_period_i = 1'b0;
  logic [15:0] bit_period_i = '0;
  logic [1:0]  parity_type_i = '0;
  logic        uart_tx_en = 1'b0;
  logic [7:0]  uart_tx_data = '0;
  logic        uart_txd;
  logic        uart_tx_busy;
  logic        uart_rxd;
  logic        uart_rx_en = 1'b1;
  logic        uart_rx_valid_o;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_parity_error_o;

  logic        loopback = 1'b0;
  logic        rxd_drv = 1'b1;
  assign uart_rxd = loopback ? uart_txd : rxd_drv;

  int checks = 0;
  int errors = 0;
  int perr_no_valid = 0;

  typedef struct {
    logic [7:0] data;
    logic       perr;
  } rx_item_t;
  rx_item_t got_q[$];

  typedef struct {
    int         wr_p;
    logic [7:0] d;
    logic [1:0] mode;
    logic       exp_par;
    int         exp_len;
    int         p;
  } tx_vec_t;
  tx_vec_t tx_vecs[6];

  always #5 clk = ~clk;

  uart_transceiver dut (
    .clk                    (clk),
    .rst                    (rst),
    .wr_bit_period_i        (wr_bit_period_i),
    .bit_period_i           (bit_period_i),
    .parity_type_i          (parity_type_i),
    .uart_tx_en             (uart_tx_en),
    .uart_tx_data           (uart_tx_data),
    .uart_txd               (uart_txd),
    .uart_tx_busy           (uart_tx_busy),
    .uart_rxd               (uart_rxd),
    .uart_rx_en             (uart_rx_en),
    .uart_rx_valid_o        (uart_rx_valid_o),
    .uart_rx_data           (uart_rx_data),
    .uart_rx_parity_error_o (uart_rx_parity_error_o)
  );

  // Collect every delivered byte; a stretched valid shows up as an extra entry.
  always @(negedge clk) begin
    rx_item_t it;
    if (!rst) begin
      if (uart_rx_valid_o) begin
        it.data = uart_rx_data;
        it.perr = uart_rx_parity_error_o;
        got_q.push_back(it);
      end else if (uart_rx_parity_error_o) begin
        perr_no_valid++;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference frame: bit 0 is the start bit, then data LSB first, optional parity, stop.
  function automatic int nbits_of(input logic [1:0] mode);
    return (mode == 2'd1 || mode == 2'd2) ? 11 : 10;
  endfunction

  function automatic logic [10:0] frame_of(input logic [7:0] d, input logic [1:0] mode,
                                           input logic flip, input logic stop);
    int   ones;
    logic p;
    ones = $countones(d);
    p = (ones % 2 == 1);
    if (mode == 2'd2) p = !p;
    if (flip) p = !p;
    if (nbits_of(mode) == 11) return {stop, p, d, 1'b0};
    return {1'b0, stop, d, 1'b0};
  endfunction

  task automatic write_period(input int v);
    @(negedge clk);
    wr_bit_period_i = 1'b1;
    bit_period_i = 16'(v);
    @(negedge clk);
    wr_bit_period_i = 1'b0;
  endtask

  task automatic tx_check(input string name, input logic [7:0] d, input logic [1:0] mode,
                          input int p, input logic exp_par, input int exp_len);
    logic [10:0] bits;
    int n, werr, bcnt;
    logic par_seen;
    bits = frame_of(d, mode, 1'b0, 1'b1);
    n = nbits_of(mode);
    werr = 0; bcnt = 0; par_seen = 1'bx;
    @(negedge clk);
    uart_tx_data = d; parity_type_i = mode; uart_tx_en = 1'b1;
    @(negedge clk);
    uart_tx_en = 1'b0;
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < p; c++) begin
        if (uart_txd !== bits[b]) werr++;
        if (uart_tx_busy === 1'b1) bcnt++;
        if (b == 9 && c == p / 2) par_seen = uart_txd;
        @(negedge clk);
      end
    end
    check({name, "_wave"}, werr, 0);
    check({name, "_busy_len"}, bcnt, exp_len);
    check({name, "_busy_end"}, uart_tx_busy, 1'b0);
    check({name, "_txd_idle"}, uart_txd, 1'b1);
    if (n == 11) check({name, "_parity"}, par_seen, exp_par);
  endtask

  task automatic rx_send(input logic [7:0] d, input logic [1:0] mode, input logic flip,
                         input logic stop, input int p, input int en_off_at);
    logic [10:0] bits;
    int n;
    bits = frame_of(d, mode, flip, stop);
    n = nbits_of(mode);
    parity_type_i = mode;
    for (int b = 0; b < n; b++) begin
      if (b == en_off_at) uart_rx_en = 1'b0;
      rxd_drv = bits[b];
      repeat (p) @(negedge clk);
    end
    rxd_drv = 1'b1;
    repeat (2 * p) @(negedge clk);
  endtask

  task automatic expect_rx(input string name, input int exp_cnt, input logic [7:0] exp_d,
                           input logic exp_perr);
    rx_item_t it;
    check({name, "_count"}, got_q.size(), exp_cnt);
    if (exp_cnt > 0 && got_q.size() > 0) begin
      it = got_q.pop_front();
      check({name, "_data"}, it.data, exp_d);
      check({name, "_perr"}, it.perr, exp_perr);
    end
    got_q.delete();
  endtask

  initial begin
    logic [10:0] bits;
    int          werr, k;
    logic [7:0]  lb_bytes[3];
    logic [7:0]  rd;
    logic [1:0]  rmode;
    logic        rflip, rstop, rperr;
    logic [7:0]  last_good;

    tx_vecs[0] = '{0, 8'hA5, 2'd0, 1'b0, 2170, 217};
    tx_vecs[1] = '{0, 8'h07, 2'd1, 1'b1, 2387, 217};
    tx_vecs[2] = '{0, 8'h07, 2'd2, 1'b0, 2387, 217};
    tx_vecs[3] = '{8, 8'h3C, 2'd3, 1'b0, 80,   8};
    tx_vecs[4] = '{2, 8'h81, 2'd1, 1'b0, 44,   4};
    tx_vecs[5] = '{5, 8'h80, 2'd2, 1'b0, 55,   5};
    lb_bytes = '{8'h00, 8'hFF, 8'h5A};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_txd", uart_txd, 1'b1);
    check("rst_busy", uart_tx_busy, 1'b0);
    check("rst_valid", uart_rx_valid_o, 1'b0);
    check("rst_data", uart_rx_data, 8'h00);
    check("rst_perr", uart_rx_parity_error_o, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      if (tx_vecs[i].wr_p > 0) write_period(tx_vecs[i].wr_p);
      tx_check($sformatf("txvec%0d", i), tx_vecs[i].d, tx_vecs[i].mode, tx_vecs[i].p,
               tx_vecs[i].exp_par, tx_vecs[i].exp_len);
    end

    // Period write and tx_en during a frame, then a back-to-back start.
    write_period(16);
    parity_type_i = 2'd0;
    @(negedge clk);
    uart_tx_data = 8'h11; uart_tx_en = 1'b1;
    @(negedge clk);
    uart_tx_en = 1'b0;
    bits = frame_of(8'h11, 2'd0, 1'b0, 1'b1);
    werr = 0;
    for (int i = 0; i < 160; i++) begin
      if (uart_txd !== bits[i / 16] || uart_tx_busy !== 1'b1) werr++;
      if (i == 39) begin wr_bit_period_i = 1'b1; bit_period_i = 16'd32; end
      if (i == 40) wr_bit_period_i = 1'b0;
      if (i == 59) begin uart_tx_data = 8'hC3; uart_tx_en = 1'b1; end
      @(negedge clk);
    end
    check("b2b_frame1_wave", werr, 0);
    check("b2b_gap_busy", uart_tx_busy, 1'b0);
    @(negedge clk);
    uart_tx_en = 1'b0;
    bits = frame_of(8'hC3, 2'd0, 1'b0, 1'b1);
    werr = 0;
    for (int i = 0; i < 320; i++) begin
      if (uart_txd !== bits[i / 32] || uart_tx_busy !== 1'b1) werr++;
      @(negedge clk);
    end
    check("b2b_frame2_wave", werr, 0);
    check("b2b_end_busy", uart_tx_busy, 1'b0);

    // Loopback, odd parity, P=16.
    write_period(16);
    parity_type_i = 2'd2;
    loopback = 1'b1;
    got_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      uart_tx_data = lb_bytes[i]; uart_tx_en = 1'b1;
      @(negedge clk);
      uart_tx_en = 1'b0;
      k = 0;
      while (uart_tx_busy && k < 2000) begin @(negedge clk); k++; end
      check($sformatf("lb%0d_done", i), uart_tx_busy, 1'b0);
      repeat (4) @(negedge clk);
      expect_rx($sformatf("lb%0d", i), 1, lb_bytes[i], 1'b0);
    end
    loopback = 1'b0;
    repeat (5) @(negedge clk);

    rx_send(8'h3C, 2'd1, 1'b1, 1'b1, 16, -1);
    expect_rx("rx_par_err", 1, 8'h3C, 1'b1);

    rxd_drv = 1'b0;
    repeat (4) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (40) @(negedge clk);
    expect_rx("rx_glitch", 0, 8'h00, 1'b0);
    check("rx_hold_after_glitch", uart_rx_data, 8'h3C);

    rx_send(8'hA7, 2'd0, 1'b0, 1'b0, 16, -1);
    expect_rx("rx_framing", 0, 8'h00, 1'b0);
    check("rx_hold_after_framing", uart_rx_data, 8'h3C);
    rx_send(8'h96, 2'd0, 1'b0, 1'b1, 16, -1);
    expect_rx("rx_after_framing", 1, 8'h96, 1'b0);

    rx_send(8'h4B, 2'd0, 1'b0, 1'b1, 16, 4);
    expect_rx("rx_en_off_mid", 1, 8'h4B, 1'b0);
    rx_send(8'hE1, 2'd0, 1'b0, 1'b1, 16, -1);
    expect_rx("rx_disabled", 0, 8'h00, 1'b0);
    uart_rx_en = 1'b1;
    repeat (4) @(negedge clk);

    last_good = 8'h4B;
    for (int i = 0; i < 10; i++) begin
      rd    = 8'($urandom);
      rmode = 2'($urandom_range(0, 3));
      rflip = 1'($urandom_range(0, 1));
      rstop = ($urandom_range(0, 4) != 0);
      rperr = rflip && (rmode == 2'd1 || rmode == 2'd2);
      rx_send(rd, rmode, rflip, rstop, 16, -1);
      if (rstop) begin
        expect_rx($sformatf("rnd%0d", i), 1, rd, rperr);
        last_good = rd;
      end else begin
        expect_rx($sformatf("rnd%0d", i), 0, 8'h00, 1'b0);
      end
      check($sformatf("rnd%0d_hold", i), uart_rx_data, last_good);
    end

    // Reset in the middle of a transmit frame.
    parity_type_i = 2'd0;
    @(negedge clk);
    uart_tx_data = 8'h5A; uart_tx_en = 1'b1;
    @(negedge clk);
    uart_tx_en = 1'b0;
    repeat (50) @(negedge clk);
    check("pre_rst_busy", uart_tx_busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_txd", uart_txd, 1'b1);
    check("midrst_busy", uart_tx_busy, 1'b0);
    check("midrst_data", uart_rx_data, 8'h00);
    rst = 1'b0;
    tx_check("tx_after_rst", 8'h3C, 2'd0, 217, 1'b0, 2170);

    check("perr_without_valid", perr_no_valid, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_transceiver.md
Name: uart_transceiver

Overview:
Full-duplex 8-bit UART with one transmitter and one receiver sharing a clock, reset and runtime-programmable bit period.
- Serial frame: 1 start bit, 8 data bits LSB-first, optional parity bit, 1 stop bit.
- At top level the receive-valid pulse can drive the transmit enable directly, giving a byte echo.

Parameters:
- BAUD_RATE, 115200: nominal baud rate.
- CLK_FREQ, 25000000: clock frequency in Hz; reset bit period is CLK_FREQ/BAUD_RATE (217 at defaults).

Ports:
- clk  in  1  sole clock.
- rst  in  1  reset.
- wr_bit_period_i  in  1  load bit_period_i into the period register.
- bit_period_i  in  16  bit period in clk cycles.
- parity_type_i  in  2  parity mode: 0 none, 1 even, 2 odd, 3 none.
- uart_tx_en  in  1  start transmission of uart_tx_data.
- uart_tx_data  in  8  byte to send.
- uart_txd  out  1  serial output; idle high.
- uart_tx_busy  out  1  high while a frame is being sent.
- uart_rxd  in  1  serial input; asynchronous to clk.
- uart_rx_en  in  1  receiver enable.
- uart_rx_valid_o  out  1  one-cycle pulse when a received byte is available.
- uart_rx_data  out  8  last received byte.
- uart_rx_parity_error_o  out  1  parity mismatch flag, qualified by valid.

Behaviour:
Clock and reset:
- One clock; reset is synchronous and active-high.
- Reset values: uart_txd=1, uart_tx_busy=0, uart_rx_valid_o=0, uart_rx_data=0, uart_rx_parity_error_o=0.
- Reset also sets the period register to CLK_FREQ/BAUD_RATE and both FSMs to IDLE.
- Reset mid-frame aborts the frame immediately.

Period register (P):
- Updated on any cycle with wr_bit_period_i=1.
- Values below 4 are stored as 4.
- Each FSM copies P at frame start, so a write during a frame affects only the next frame.

TX FSM (IDLE, START, DATA, PARITY, STOP):
- IDLE: txd=1, busy=0.
- uart_tx_en=1 in IDLE latches data and parity mode. The next cycle txd=0 and busy=1.
- Each bit is held exactly P cycles. Data is sent LSB first.
- PARITY state is skipped when mode is none.
- Even parity bit = XOR of the data bits. Odd parity bit = its inverse.
- STOP drives 1 for P cycles, then returns to IDLE with busy=0.
- Frame length is 10*P cycles (11*P with parity).
- uart_tx_en while busy is ignored; no queueing.
- uart_tx_en in the first IDLE cycle after STOP starts a new frame back-to-back.

RX FSM (IDLE, START, DATA, PARITY, STOP):
- uart_rxd passes through a 2-flop synchronizer; all timing is relative to the synchronized signal.
- IDLE: a falling edge with uart_rx_en=1 enters START.
- START: wait P/2 cycles (integer divide), then sample. If the sample is high, treat it as a glitch and return to IDLE.
- DATA, PARITY and STOP bits are each sampled P cycles after the previous sample (mid-bit). Data is shifted in LSB first.
- Stop sample = 1: in the next cycle uart_rx_data updates, uart_rx_valid_o pulses for exactly 1 cycle, and parity_error_o = (parity enabled AND received parity ≠ expected).
- A byte with a parity error is still delivered.
- parity_error_o is 0 when valid is 0.
- Stop sample = 0 (framing error): drop the frame, no valid pulse, and wait for rxd high before re-arming.
- uart_rx_en=0 mid-frame: the current frame completes; new frames are not started.
- uart_rx_data holds its value between frames.
- TX and RX operate fully independently; simultaneous activity is legal.

Decomposition:
- Package uart_pkg:
  - parity_e enum (PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2);
  - state enum shared by TX and RX;
  - BIT_PERIOD_W=16;
  - MIN_BIT_PERIOD=4.
- One sub-module, uart_bit_timer: loadable down-counter producing a tick after N cycles, instantiated once in TX and once in RX.
- TX and RX FSMs live in the top module.

Test Plan:
- Default P=217, parity none, tx_en with 0xA5 → txd is 0 for 217 cycles, then 1,0,1,0,0,1,0,1, then stop 1. busy high for exactly 2170 cycles.
- Parity even, send 0x07 → parity bit 1. Parity odd, send 0x07 → parity bit 0. Frame length 2387 cycles.
- Loopback txd→rxd with P=16 (written via wr_bit_period_i), parity odd, bytes 0x00, 0xFF, 0x5A → three valid pulses with matching data and parity_error_o=0.
- Drive an RX frame with an inverted parity bit for 0x3C, even mode → valid pulses, data=0x3C, parity_error_o=1.
- rxd low pulse of P/4 cycles → no valid. Frame with stop bit 0 → no valid, and the next good frame is received correctly.
- Write P=32 mid-TX frame → current frame keeps the old period, next frame uses 32. tx_en while busy → ignored. rst mid-frame → txd=1 and busy=0 on the next cycle.
